// File: rtl/parking_timer_pkg.sv
// Shared definitions for the parking controller's time-shared tick timer.
// Holds the timer FSM state encoding, the default clk-to-tick divider that
// the gate and LED controllers also use, and a small index-width helper.
package parking_timer_pkg;

  // State codes kept as named constants so other controllers can decode busy
  // states from a debug bus without depending on the enum type.
  localparam logic [1:0] IDLE_CODE = 2'b00;
  localparam logic [1:0] RUN_CODE  = 2'b01;
  localparam logic [1:0] FIN_CODE  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = IDLE_CODE,
    RUN  = RUN_CODE,
    FIN  = FIN_CODE
  } state_t;

  // clk cycles per timer tick on the production board.
  localparam int TICK_DIV_DEFAULT = 40_000_000;

  // Width of a binary index into n requesters; never less than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Ports:
//   req     - request vector, one bit per requester
//   ptr     - index that has top priority this round; search wraps upward
//   valid   - arbitration strobe; when low no winner is produced
//   winner  - one-hot winner (all zero when no request or valid low)
//   win_idx - binary index of the winner (zero when there is none)
module rr_arbiter
  import parking_timer_pkg::*;
#(
  parameter  int NUM_REQ = 3,
  localparam int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               valid,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   win_idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    winner  = '0;
    win_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (valid && !found && req[cand]) begin
        found         = 1'b1;
        winner[cand]  = 1'b1;
        win_idx       = cand;
      end
    end
  end

endmodule

// File: rtl/shared_timer_arbiter.sv
// One programmable tick timer time-shared between NUM_REQ requesters
// (entry gate, exit gate, alarm/LED sequencer). Requesters are picked
// round-robin; the winner's duration is counted in ticks of TICK_DIV clk
// cycles, and the winner's done line pulses when it expires.
// Ports:
//   clk     - system clock
//   reset_n - asynchronous active-low reset
//   req     - level request per requester; dropping it while owning aborts
//   len     - duration in ticks, requester i at [i*CNT_W +: CNT_W]
//   grant   - registered one-hot owner of the timer
//   done    - registered one-cycle expiry pulse for the owner
//   busy    - timer is counting (state RUN)
//   tick    - one-cycle pulse at each tick boundary while counting
module shared_timer_arbiter
  import parking_timer_pkg::*;
#(
  parameter  int NUM_REQ  = 3,
  parameter  int TICK_DIV = TICK_DIV_DEFAULT,
  parameter  int CNT_W    = 8,
  localparam int IDX_W    = idx_w(NUM_REQ),
  localparam int PRE_W    = $clog2(TICK_DIV)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] len,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic                     tick
);

  state_t               state, next_state;
  logic [IDX_W-1:0]     ptr, owner, win_idx, next_ptr;
  logic [NUM_REQ-1:0]   winner;
  logic [PRE_W-1:0]     prescaler;
  logic [CNT_W-1:0]     remaining, win_len;
  logic                 arb_valid, win_any, tick_hit, last_tick, abort;

  // Arbitration is held off while a done pulse is still showing, so a
  // requester that drops req on seeing done is never re-granted.
  assign arb_valid = (state == IDLE) && (done == '0);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req     (req),
    .ptr     (ptr),
    .valid   (arb_valid),
    .winner  (winner),
    .win_idx (win_idx)
  );

  assign win_any   = |winner;
  assign win_len   = len[win_idx*CNT_W +: CNT_W];
  assign next_ptr  = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
  assign abort     = (state == RUN) && !req[owner];
  assign tick_hit  = (state == RUN) && (prescaler == PRE_W'(TICK_DIV - 1));
  assign last_tick = tick_hit && (remaining == CNT_W'(1));
  assign tick      = tick_hit;
  assign busy      = (state == RUN);

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (win_any) next_state = (win_len == '0) ? FIN : RUN;
      // A final tick coinciding with req falling counts as an abort.
      RUN:     if (abort)          next_state = IDLE;
               else if (last_tick) next_state = FIN;
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant     <= '0;
      done      <= '0;
      ptr       <= '0;
      owner     <= '0;
      prescaler <= '0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= '0;
          if (win_any) begin
            grant     <= winner;
            owner     <= win_idx;
            remaining <= win_len;
            prescaler <= '0;
            ptr       <= next_ptr;
          end
        end
        RUN: begin
          if (abort) begin
            grant <= '0;
          end else if (tick_hit) begin
            prescaler <= '0;
            remaining <= remaining - 1'b1;
            if (last_tick) begin
              grant <= '0;
              done  <= grant;
            end
          end else begin
            prescaler <= prescaler + 1'b1;
          end
        end
        FIN: begin
          // Grant is only still set here on the zero-length path; the done
          // pulse for that case is qualified by the owner's live request.
          grant <= '0;
          done  <= grant & req;
        end
        default: begin
          grant <= '0;
          done  <= '0;
        end
      endcase
    end
  end

endmodule
